// File: rtl/vga_stream_tx.sv
// VGA transmitter: timing generator plus prefetch FIFO. Video outputs register one tick after the (h,v) they describe.
// Backpressure: s_ready is low only while the FIFO is full; the raster never stalls and shows FILL_RGB instead.

module vga_stream_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
endmodule

module vga_stream_tx #(
    parameter int          H_VISIBLE  = 640,
    parameter int          H_FRONT    = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BACK     = 48,
    parameter int          V_VISIBLE  = 480,
    parameter int          V_FRONT    = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BACK     = 33,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [23:0] FILL_RGB   = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_sof,
    input  logic        err_clr,
    output logic        vga_clock,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [23:0] rgb,
    output logic        frame_start,
    output logic        underflow,
    output logic        sof_err
);
    localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    localparam logic [HW-1:0] H_LAST     = HW'(HT - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(VT - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic {
        ST_ALIGN,
        ST_RUN
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          vga_clock_q;
    logic          vga_clock_d;
    logic          hsync_q;
    logic          hsync_d;
    logic          vsync_q;
    logic          vsync_d;
    logic          blank_q;
    logic          blank_d;
    logic [23:0]   rgb_q;
    logic [23:0]   rgb_d;
    logic          frame_start_q;
    logic          frame_start_d;
    logic          underflow_q;
    logic          underflow_d;
    logic          sof_err_q;
    logic          sof_err_d;
    logic [HW-1:0] h_q;
    logic [HW-1:0] h_d;
    logic [VW-1:0] v_q;
    logic [VW-1:0] v_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [24:0]   head;
    logic          head_sof;
    logic [23:0]   head_rgb;
    logic          tick;
    logic          vis;
    logic          origin;
    logic          set_uf;
    logic          set_se;

    vga_stream_fifo #(
        .W     (25),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat ({s_sof, s_data}),
        .pop      (fifo_pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign s_ready   = ~fifo_full;
    assign fifo_push = s_valid & s_ready;
    assign head_sof  = head[24];
    assign head_rgb  = head[23:0];
    assign tick      = vga_clock_q;
    assign vis       = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    assign origin    = (h_q == '0) && (v_q == '0);

    always_comb begin
        vga_clock_d   = ~vga_clock_q;
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_d       = blank_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;
        fifo_pop      = 1'b0;
        set_uf        = 1'b0;
        set_se        = 1'b0;

        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            blank_d       = vis;
            frame_start_d = origin;
            hsync_d       = ~((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
            vsync_d       = ~((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));

            if (!vis) begin
                rgb_d = '0;
            end else if (state_q == ST_ALIGN) begin
                if (origin && !fifo_empty && head_sof) begin
                    fifo_pop = 1'b1;
                    rgb_d    = head_rgb;
                    state_d  = ST_RUN;
                end else begin
                    rgb_d = FILL_RGB;
                end
            end else if (fifo_empty) begin
                rgb_d   = FILL_RGB;
                set_uf  = 1'b1;
                state_d = ST_ALIGN;
            end else if (head_sof && !origin) begin
                // Early sof stays queued so it can start the next frame.
                rgb_d   = FILL_RGB;
                set_se  = 1'b1;
                state_d = ST_ALIGN;
            end else begin
                fifo_pop = 1'b1;
                rgb_d    = head_rgb;
                if (!head_sof && origin) begin
                    set_se  = 1'b1;
                    state_d = ST_ALIGN;
                end
            end
        end else if (state_q == ST_ALIGN && !fifo_empty && !head_sof) begin
            // Between ticks, drain stale pixels so a waiting sof reaches the head.
            fifo_pop = 1'b1;
        end

        underflow_d = set_uf | (underflow_q & ~err_clr);
        sof_err_d   = set_se | (sof_err_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_ALIGN;
            vga_clock_q   <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            sof_err_q     <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
        end else begin
            state_q       <= state_d;
            vga_clock_q   <= vga_clock_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            sof_err_q     <= sof_err_d;
            h_q           <= h_d;
            v_q           <= v_d;
        end
    end

    assign vga_clock   = vga_clock_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign sof_err     = sof_err_q;
endmodule
